// File: rtl/riscv_v_mul_pipe_if.sv
// Request/response bundle between the vector execute stage and the SIMD multiplier.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
`ifndef RISCV_V_DATA_WIDTH
`define RISCV_V_DATA_WIDTH 128
`endif

interface riscv_v_mul_pipe_if #(
    parameter int DATA_WIDTH = `RISCV_V_DATA_WIDTH,
    parameter int TAG_WIDTH  = 5
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_a;
    logic [DATA_WIDTH-1:0]   in_b;
    logic [3:0]              in_osize;
    logic [1:0]              in_sign_mode;
    logic                    in_high;
    logic [DATA_WIDTH/8-1:0] in_mask;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [TAG_WIDTH-1:0]    out_tag;
    logic                    out_err;

    modport master (
        output flush, in_valid, in_a, in_b, in_osize, in_sign_mode, in_high, in_mask, in_tag,
        output out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, in_osize, in_sign_mode, in_high, in_mask, in_tag,
        input  out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/riscv_v_mul_pipe.sv
// Pipelined SIMD multiplier, SEW 8/16/32/64, UU/SS/SU, low or high half, per-byte mask.
// Latency: PIPE_STAGES cycles from accept to out_valid, one op per cycle.
// Backpressure: a stage advances when its successor is empty or advancing; in_ready follows stage0.
`ifndef RISCV_V_DATA_WIDTH
`define RISCV_V_DATA_WIDTH 128
`endif

module riscv_v_mul_pipe #(
    parameter int DATA_WIDTH  = `RISCV_V_DATA_WIDTH,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_WIDTH   = 5
) (
    input logic               clk,
    input logic               rst_n,
    riscv_v_mul_pipe_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int NB = DW / 8;

    // dat holds {|B|,|A|} in stage0, element magnitude products in the middle, final result last
    typedef struct packed {
        logic [2*DW-1:0]      dat;
        logic [NB-1:0]        neg;
        logic [3:0]           osize;
        logic                 high;
        logic [NB-1:0]        mask;
        logic [TAG_WIDTH-1:0] tag;
        logic                 err;
    } stg_t;

    stg_t                   stg_q [PIPE_STAGES];
    stg_t                   stg_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] adv;
    logic                   accept;

    // Sign bit of the element each byte belongs to, replicated over the element's bytes.
    function automatic logic [NB-1:0] byte_sign(input logic [DW-1:0] x, input logic [3:0] os);
        logic [NB-1:0] s;
        int            bpe;
        bpe = os[0] ? 1 : (os[1] ? 2 : (os[2] ? 4 : 8));
        for (int j = 0; j < NB; j++) s[j] = x[8*(j | (bpe-1)) + 7];
        return s;
    endfunction

    function automatic logic [DW-1:0] neg_elems(input logic [DW-1:0] x, input logic [NB-1:0] f,
                                                input logic [3:0] os);
        logic [DW-1:0] r;
        r = x;
        case (os)
            4'b0001: for (int i = 0; i < NB;   i++) if (f[i])   r[8*i  +: 8]  = -x[8*i  +: 8];
            4'b0010: for (int i = 0; i < NB/2; i++) if (f[2*i]) r[16*i +: 16] = -x[16*i +: 16];
            4'b0100: for (int i = 0; i < NB/4; i++) if (f[4*i]) r[32*i +: 32] = -x[32*i +: 32];
            4'b1000: for (int i = 0; i < NB/8; i++) if (f[8*i]) r[64*i +: 64] = -x[64*i +: 64];
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [2*DW-1:0] neg_prods(input logic [2*DW-1:0] x, input logic [NB-1:0] f,
                                                  input logic [3:0] os);
        logic [2*DW-1:0] r;
        r = x;
        case (os)
            4'b0001: for (int i = 0; i < NB;   i++) if (f[i])   r[16*i  +: 16]  = -x[16*i  +: 16];
            4'b0010: for (int i = 0; i < NB/2; i++) if (f[2*i]) r[32*i  +: 32]  = -x[32*i  +: 32];
            4'b0100: for (int i = 0; i < NB/4; i++) if (f[4*i]) r[64*i  +: 64]  = -x[64*i  +: 64];
            4'b1000: for (int i = 0; i < NB/8; i++) if (f[8*i]) r[128*i +: 128] = -x[128*i +: 128];
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [2*DW-1:0] mul_mag(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [3:0] os);
        logic [2*DW-1:0] r;
        r = '0;
        case (os)
            4'b0001: for (int i = 0; i < NB; i++)
                r[16*i +: 16] = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
            4'b0010: for (int i = 0; i < NB/2; i++)
                r[32*i +: 32] = 32'(a[16*i +: 16]) * 32'(b[16*i +: 16]);
            4'b0100: for (int i = 0; i < NB/4; i++)
                r[64*i +: 64] = 64'(a[32*i +: 32]) * 64'(b[32*i +: 32]);
            4'b1000: for (int i = 0; i < NB/8; i++)
                r[128*i +: 128] = 128'(a[64*i +: 64]) * 128'(b[64*i +: 64]);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] finalize(input logic [2*DW-1:0] p, input logic [NB-1:0] f,
                                               input logic [3:0] os, input logic hi,
                                               input logic [NB-1:0] m, input logic err);
        logic [2*DW-1:0] pn;
        logic [DW-1:0]   r;
        pn = neg_prods(p, f, os);
        r  = '0;
        case (os)
            4'b0001: for (int i = 0; i < NB;   i++) r[8*i  +: 8]  = hi ? pn[16*i+8   +: 8]  : pn[16*i  +: 8];
            4'b0010: for (int i = 0; i < NB/2; i++) r[16*i +: 16] = hi ? pn[32*i+16  +: 16] : pn[32*i  +: 16];
            4'b0100: for (int i = 0; i < NB/4; i++) r[32*i +: 32] = hi ? pn[64*i+32  +: 32] : pn[64*i  +: 32];
            4'b1000: for (int i = 0; i < NB/8; i++) r[64*i +: 64] = hi ? pn[128*i+64 +: 64] : pn[128*i +: 64];
            default: r = '0;
        endcase
        for (int j = 0; j < NB; j++) if (!m[j] || err) r[8*j +: 8] = 8'h00;
        return r;
    endfunction

    always_comb begin
        logic            sa_en;
        logic            sb_en;
        logic [NB-1:0]   sa;
        logic [NB-1:0]   sb;
        logic [2*DW-1:0] p;
        sa_en = (bus.in_sign_mode == 2'b01) || (bus.in_sign_mode == 2'b10);
        sb_en = (bus.in_sign_mode == 2'b01);
        sa    = byte_sign(bus.in_a, bus.in_osize) & {NB{sa_en}};
        sb    = byte_sign(bus.in_b, bus.in_osize) & {NB{sb_en}};
        stg_d[0].dat   = {neg_elems(bus.in_b, sb, bus.in_osize), neg_elems(bus.in_a, sa, bus.in_osize)};
        stg_d[0].neg   = sa ^ sb;
        stg_d[0].osize = bus.in_osize;
        stg_d[0].high  = bus.in_high;
        stg_d[0].mask  = bus.in_mask;
        stg_d[0].tag   = bus.in_tag;
        stg_d[0].err   = !$onehot(bus.in_osize) || (bus.in_sign_mode == 2'b11);
        for (int k = 1; k < PIPE_STAGES; k++) begin
            stg_d[k] = stg_q[k-1];
            p        = stg_q[k-1].dat;
            if (k == 1) p = mul_mag(stg_q[0].dat[DW-1:0], stg_q[0].dat[2*DW-1:DW], stg_q[0].osize);
            if (k == PIPE_STAGES-1)
                p = {{DW{1'b0}}, finalize(p, stg_q[k-1].neg, stg_q[k-1].osize, stg_q[k-1].high,
                                          stg_q[k-1].mask, stg_q[k-1].err)};
            stg_d[k].dat = p;
        end
    end

    // A stage moves when any later stage has a hole, or the whole tail is full and the sink takes.
    always_comb begin
        logic full_above;
        full_above = 1'b1;
        adv        = '0;
        for (int k = PIPE_STAGES-1; k >= 0; k--) begin
            adv[k]     = vld[k] & (bus.out_ready | ~full_above);
            full_above = full_above & vld[k];
        end
    end

    assign bus.in_ready = !vld[0] || adv[0];
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) stg_q[k] <= '0;
        end else if (bus.flush) begin
            vld <= '0;
        end else begin
            if (bus.in_ready) begin
                vld[0] <= accept;
                if (accept) stg_q[0] <= stg_d[0];
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (!vld[k] || adv[k]) begin
                    vld[k] <= adv[k-1];
                    if (adv[k-1]) stg_q[k] <= stg_d[k];
                end
            end
        end
    end

    assign bus.out_valid = vld[PIPE_STAGES-1];
    assign bus.out_data  = stg_q[PIPE_STAGES-1].dat[DW-1:0];
    assign bus.out_tag   = stg_q[PIPE_STAGES-1].tag;
    assign bus.out_err   = stg_q[PIPE_STAGES-1].err;
endmodule

// File: tb/tb_riscv_v_mul_pipe.sv
// Bench for riscv_v_mul_pipe: directed corner products, handshake scenarios and a random
// stream against an arithmetic reference model.
module tb_riscv_v_mul_pipe;
    localparam int DW = 128;
    localparam int P  = 3;
    localparam int TW = 5;
    localparam int NB = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
        int            c;
    } res_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_low = 0;
    res_t got_q[$];

    riscv_v_mul_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) mif ();

    riscv_v_mul_pipe #(.DATA_WIDTH(DW), .PIPE_STAGES(P), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (mif.out_valid === 1'b1 && mif.out_ready === 1'b1)
            got_q.push_back('{mif.out_data, mif.out_tag, mif.out_err, cyc});
        if (mif.in_valid === 1'b1 && mif.in_ready === 1'b0) rdy_low++;
    end

    // Exact per-element product from sign-extended integers; no knowledge of the pipeline.
    function automatic exp_t ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [3:0] os, input logic [1:0] sm, input logic hi,
                                    input logic [NB-1:0] m, input logic [TW-1:0] tag);
        exp_t               r;
        int                 sew;
        logic signed [131:0] ea, eb, p, lim;
        r.tag  = tag;
        r.err  = !$onehot(os) || sm == 2'b11;
        r.data = '0;
        if (!r.err) begin
            sew = os[0] ? 8 : (os[1] ? 16 : (os[2] ? 32 : 64));
            lim = (132'sd1 <<< sew) - 132'sd1;
            for (int e = 0; e < DW / sew; e++) begin
                ea = $signed(132'(a >> (e * sew))) & lim;
                eb = $signed(132'(b >> (e * sew))) & lim;
                if ((sm == 2'b01 || sm == 2'b10) && ea[sew-1]) ea = ea - (132'sd1 <<< sew);
                if (sm == 2'b01 && eb[sew-1]) eb = eb - (132'sd1 <<< sew);
                p = ea * eb;
                if (hi) p = p >>> sew;
                p = p & lim;
                r.data = r.data | (DW'(p) << (e * sew));
            end
            for (int j = 0; j < NB; j++) if (!m[j]) r.data[8*j +: 8] = 8'h00;
        end
        return r;
    endfunction

    task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] os,
                           input logic [1:0] sm, input logic hi, input logic [NB-1:0] m,
                           input logic [TW-1:0] tag, output int acc);
        int n;
        @(negedge clk);
        mif.in_a = a; mif.in_b = b; mif.in_osize = os; mif.in_sign_mode = sm;
        mif.in_high = hi; mif.in_mask = m; mif.in_tag = tag; mif.in_valid = 1'b1;
        n = 0;
        #1;
        while (mif.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stuck at %b, required 1 (tag %0d)", mif.in_ready, tag);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        #2;
        ok = (got_q.size() >= n);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout: %0d results seen, %0d required", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mif.flush = 1'b0; mif.in_valid = 1'b0; mif.out_ready = 1'b1;
        mif.in_a = '0; mif.in_b = '0; mif.in_osize = 4'b0001; mif.in_sign_mode = 2'b00;
        mif.in_high = 1'b0; mif.in_mask = '1; mif.in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp += 5;
        if (mif.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", mif.out_valid); end
        if (mif.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", mif.out_data); end
        if (mif.out_tag !== '0) begin n_bad++; $display("FAIL reset_out_tag: got %h want 0", mif.out_tag); end
        if (mif.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", mif.out_err); end
        if (mif.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", mif.in_ready); end
        got_q.delete();
    endtask

    task automatic test_directed();
        logic [DW-1:0] va[10], vb[10], vx[10];
        logic [3:0]    vos[10];
        logic [1:0]    vsm[10];
        logic          vhi[10];
        logic [63:0]   m3, c5, r64;
        int            acc;
        bit            ok;
        res_t          g;
        m3 = -64'sd3; c5 = 64'd5; r64 = 64'hFFFF_FFFF_FFFF_FFF1;
        for (int i = 0; i < 6; i++) begin
            va[i] = '1; vb[i] = '1; vos[i] = 4'b0001;
            vsm[i] = (i < 2) ? 2'b01 : ((i < 4) ? 2'b00 : 2'b10);
            vhi[i] = i[0];
        end
        vx[0] = {16{8'h01}}; vx[1] = '0;
        vx[2] = {16{8'h01}}; vx[3] = {16{8'hFE}};
        vx[4] = {16{8'h01}}; vx[5] = {16{8'hFF}};
        for (int i = 6; i < 8; i++) begin
            va[i] = {4{32'h8000_0000}}; vb[i] = va[i]; vos[i] = 4'b0100; vsm[i] = 2'b01; vhi[i] = (i == 7);
        end
        vx[6] = '0; vx[7] = {4{32'h4000_0000}};
        for (int i = 8; i < 10; i++) begin
            va[i] = {m3, m3}; vb[i] = {c5, c5}; vos[i] = 4'b1000; vsm[i] = 2'b01; vhi[i] = (i == 9);
        end
        vx[8] = {r64, r64}; vx[9] = '1;
        for (int i = 0; i < 10; i++) begin
            got_q.delete();
            send_op(va[i], vb[i], vos[i], vsm[i], vhi[i], '1, TW'(i + 10), acc);
            wait_n(1, 20, ok);
            if (ok) begin
                g = got_q.pop_front();
                n_cmp += 3;
                if (g.data !== vx[i]) begin n_bad++; $display("FAIL directed_%0d_data: got %h want %h", i, g.data, vx[i]); end
                if (g.tag !== TW'(i + 10)) begin n_bad++; $display("FAIL directed_%0d_tag: got %0d want %0d", i, g.tag, i + 10); end
                if (g.err !== 1'b0) begin n_bad++; $display("FAIL directed_%0d_err: got %b want 0", i, g.err); end
            end
        end
    endtask

    task automatic test_latency();
        int   acc;
        bit   ok;
        res_t g;
        exp_t e;
        got_q.delete();
        e = ref_op({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, 4'b0010, 2'b10, 1'b1, '1, 5'd3);
        send_op({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, 4'b0010, 2'b10, 1'b1, '1, 5'd3, acc);
        wait_n(1, 20, ok);
        if (ok) begin
            g = got_q.pop_front();
            n_cmp += 2;
            if (g.c - acc !== P) begin n_bad++; $display("FAIL latency: got %0d cycles want %0d", g.c - acc, P); end
            if (g.data !== e.data) begin n_bad++; $display("FAIL latency_data: got %h want %h", g.data, e.data); end
        end
    endtask

    task automatic test_err_and_mask();
        int            acc;
        bit            ok;
        res_t          g;
        exp_t          e;
        logic [DW-1:0] a, b;
        got_q.delete();
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        e = ref_op(a, b, 4'b0010, 2'b00, 1'b0, 16'h000F, 5'd12);
        send_op(a, b, 4'b0011, 2'b00, 1'b0, '1, 5'd7, acc);
        send_op(a, b, 4'b0001, 2'b11, 1'b1, '1, 5'd9, acc);
        send_op(a, b, 4'b0010, 2'b00, 1'b0, 16'h000F, 5'd12, acc);
        wait_n(3, 30, ok);
        if (ok) begin
            g = got_q.pop_front();
            n_cmp += 3;
            if (g.err !== 1'b1) begin n_bad++; $display("FAIL err_osize_err: got %b want 1", g.err); end
            if (g.data !== '0) begin n_bad++; $display("FAIL err_osize_data: got %h want 0", g.data); end
            if (g.tag !== 5'd7) begin n_bad++; $display("FAIL err_osize_tag: got %0d want 7", g.tag); end
            g = got_q.pop_front();
            n_cmp += 2;
            if (g.err !== 1'b1) begin n_bad++; $display("FAIL err_sign_err: got %b want 1", g.err); end
            if (g.data !== '0) begin n_bad++; $display("FAIL err_sign_data: got %h want 0", g.data); end
            g = got_q.pop_front();
            n_cmp += 3;
            if (g.data[DW-1:32] !== '0) begin n_bad++; $display("FAIL mask_upper: got %h want 0", g.data[DW-1:32]); end
            if (g.data !== e.data) begin n_bad++; $display("FAIL mask_data: got %h want %h", g.data, e.data); end
            if (g.err !== 1'b0) begin n_bad++; $display("FAIL mask_err: got %b want 0", g.err); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t          eq[$];
        exp_t          e;
        res_t          g;
        logic [DW-1:0] a, b;
        int            acc, prev_c;
        bit            ok;
        got_q.delete();
        rdy_low = 0;
        fork
            begin
                mif.out_ready = 1'b0;
                repeat (6) @(negedge clk);
                mif.out_ready = 1'b1;
            end
            begin
                for (int i = 1; i <= 4; i++) begin
                    a = {$urandom, $urandom, $urandom, $urandom};
                    b = {$urandom, $urandom, $urandom, $urandom};
                    eq.push_back(ref_op(a, b, 4'b0100, 2'b01, 1'b1, '1, TW'(i)));
                    send_op(a, b, 4'b0100, 2'b01, 1'b1, '1, TW'(i), acc);
                end
            end
        join
        wait_n(4, 40, ok);
        n_cmp++;
        if (rdy_low == 0) begin n_bad++; $display("FAIL b2b_in_ready_drop: low cycles %0d, required > 0", rdy_low); end
        prev_c = -1;
        while (got_q.size() > 0 && eq.size() > 0) begin
            g = got_q.pop_front();
            e = eq.pop_front();
            n_cmp += 2;
            if (g.tag !== e.tag) begin n_bad++; $display("FAIL b2b_tag: got %0d want %0d", g.tag, e.tag); end
            if (g.data !== e.data) begin n_bad++; $display("FAIL b2b_data_tag%0d: got %h want %h", e.tag, g.data, e.data); end
            if (prev_c >= 0) begin
                n_cmp++;
                if (g.c !== prev_c + 1) begin n_bad++; $display("FAIL b2b_gap: result at cycle %0d, want %0d", g.c, prev_c + 1); end
            end
            prev_c = g.c;
        end
    endtask

    task automatic test_flush();
        int   acc;
        bit   ok;
        res_t g;
        exp_t e;
        got_q.delete();
        mif.out_ready = 1'b1;
        send_op({8{16'h00FF}}, {8{16'h0101}}, 4'b0010, 2'b00, 1'b0, '1, 5'd21, acc);
        send_op({8{16'h00FF}}, {8{16'h0202}}, 4'b0010, 2'b00, 1'b0, '1, 5'd22, acc);
        @(negedge clk);
        mif.in_tag = 5'd23; mif.in_valid = 1'b1; mif.flush = 1'b1;
        #1;
        n_cmp++;
        if (mif.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", mif.in_ready); end
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0; mif.flush = 1'b0;
        repeat (P + 3) @(negedge clk);
        #2;
        n_cmp++;
        if (got_q.size() !== 0) begin n_bad++; $display("FAIL flush_killed: %0d results emerged, want 0", got_q.size()); end
        got_q.delete();
        e = ref_op({2{64'hFFFF_FFFF_FFFF_FFFD}}, {2{64'd7}}, 4'b1000, 2'b10, 1'b0, '1, 5'd24);
        send_op({2{64'hFFFF_FFFF_FFFF_FFFD}}, {2{64'd7}}, 4'b1000, 2'b10, 1'b0, '1, 5'd24, acc);
        wait_n(1, 20, ok);
        if (ok) begin
            g = got_q.pop_front();
            n_cmp += 3;
            if (g.c - acc !== P) begin n_bad++; $display("FAIL flush_next_latency: got %0d want %0d", g.c - acc, P); end
            if (g.tag !== 5'd24) begin n_bad++; $display("FAIL flush_next_tag: got %0d want 24", g.tag); end
            if (g.data !== e.data) begin n_bad++; $display("FAIL flush_next_data: got %h want %h", g.data, e.data); end
        end
    endtask

    task automatic test_reset_midflight();
        int acc;
        got_q.delete();
        mif.out_ready = 1'b0;
        send_op('1, '1, 4'b0001, 2'b00, 1'b1, '1, 5'd30, acc);
        send_op('1, '1, 4'b0001, 2'b00, 1'b1, '1, 5'd31, acc);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp += 3;
        if (mif.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", mif.out_valid); end
        if (mif.out_data !== '0) begin n_bad++; $display("FAIL rstmid_out_data: got %h want 0", mif.out_data); end
        if (mif.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", mif.in_ready); end
        mif.out_ready = 1'b1;
        repeat (P + 3) @(negedge clk);
        #2;
        n_cmp++;
        if (got_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_discard: %0d results emerged, want 0", got_q.size()); end
    endtask

    task automatic test_random();
        exp_t eq[$];
        exp_t e;
        res_t g;
        bit   done, ok;
        int   idx;
        got_q.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [DW-1:0] a, b;
                    logic [3:0]    os;
                    logic [1:0]    sm;
                    logic          hi;
                    logic [NB-1:0] m;
                    int            r, acc;
                    a  = {$urandom, $urandom, $urandom, $urandom};
                    b  = {$urandom, $urandom, $urandom, $urandom};
                    r  = $urandom_range(0, 9);
                    os = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom);
                    sm = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                    hi = 1'($urandom);
                    m  = ($urandom_range(0, 1) == 1) ? '1 : NB'($urandom);
                    eq.push_back(ref_op(a, b, os, sm, hi, m, TW'(i)));
                    send_op(a, b, os, sm, hi, m, TW'(i), acc);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    mif.out_ready = ($urandom_range(0, 3) != 0);
                end
                mif.out_ready = 1'b1;
            end
        join
        wait_n(60, 400, ok);
        idx = 0;
        while (got_q.size() > 0 && eq.size() > 0) begin
            g = got_q.pop_front();
            e = eq.pop_front();
            n_cmp += 3;
            if (g.tag !== e.tag) begin n_bad++; $display("FAIL rand_%0d_tag: got %0d want %0d", idx, g.tag, e.tag); end
            if (g.data !== e.data) begin n_bad++; $display("FAIL rand_%0d_data: got %h want %h", idx, g.data, e.data); end
            if (g.err !== e.err) begin n_bad++; $display("FAIL rand_%0d_err: got %b want %b", idx, g.err, e.err); end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_err_and_mask();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
